sumador_multiciclo_param: RTL and testbench



---
 rtl/sumador_multiciclo_param_pkg.sv | 22 ++
 rtl/sumador_multiciclo_param_bloque.sv | 26 ++
 rtl/sumador_multiciclo_param.sv | 131 +++++++++++++
 tb/tb_sumador_multiciclo_param.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sumador_multiciclo_param_pkg.sv
// Shared types and helpers for the multi-cycle adder/subtractor.
// Holds the FSM state enum, the add/sub mode constants and a clog2 helper.
package sumador_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    // Index width; never below 1 so a single-chunk build still has a counter.
    function automatic int clog2(input int v);
        int r;
        r = 1;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/sumador_multiciclo_param_bloque.sv
// CHUNK-bit combinational ripple adder made of full-adder cells.
// Ports: x, z operands; cin carry in; s sum; cout carry out; c_msb_in carry into MSB.
module sumador_bloque #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] z,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout,
    output logic             c_msb_in
);

    logic [CHUNK:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        assign s[i]   = x[i] ^ z[i] ^ c[i];
        assign c[i+1] = (x[i] & z[i]) | (c[i] & (x[i] ^ z[i]));
    end

    assign cout     = c[CHUNK];
    assign c_msb_in = c[CHUNK-1];

endmodule

// File: rtl/sumador_multiciclo_param.sv
// Multi-cycle add/sub: one CHUNK-bit slice per clock, valid/ready on both sides.
// Ports: clk, rst_n (sync, active-low); in_valid/in_ready, a, b, ci, sub in;
//        out_valid/out_ready, y, co, ovf out.
module sumador_multiciclo_param
    import sumador_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             co,
    output logic             ovf
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IW     = clog2(NCHUNK);
    localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);

    if (WIDTH < 2 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
        $error("sumador_multiciclo_param: WIDTH/CHUNK invalid");
    end

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             c_q, c_d;
    logic             co_q, co_d;
    logic             ovf_q, ovf_d;
    logic [IW-1:0]    idx_q, idx_d;

    logic [CHUNK-1:0] x_sl, z_sl, s_sl;
    logic             cout, c_msb_in;
    logic             accept;

    assign x_sl = a_q[idx_q*CHUNK +: CHUNK];
    assign z_sl = b_q[idx_q*CHUNK +: CHUNK];

    sumador_bloque #(
        .CHUNK (CHUNK)
    ) u_bloque (
        .x        (x_sl),
        .z        (z_sl),
        .cin      (c_q),
        .s        (s_sl),
        .cout     (cout),
        .c_msb_in (c_msb_in)
    );

    assign in_ready  = rst_n &
                       ((state_q == IDLE) |
                        ((state_q == DONE) & out_ready));
    assign accept    = in_valid & in_ready;
    assign out_valid = (state_q == DONE);
    assign y         = y_q;
    assign co        = co_q;
    assign ovf       = ovf_q;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        y_d     = y_q;
        c_d     = c_q;
        co_d    = co_q;
        ovf_d   = ovf_q;
        idx_d   = idx_q;

        unique case (state_q)
            IDLE: ;
            RUN: begin
                y_d[idx_q*CHUNK +: CHUNK] = s_sl;
                c_d = cout;
                if (idx_q == LAST) begin
                    co_d    = cout;
                    ovf_d   = cout ^ c_msb_in;
                    idx_d   = '0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Subtraction runs as a + ~b + ~ci, so the inversion happens at capture.
        if (accept) begin
            a_d     = a;
            b_d     = (sub == MODE_SUB) ? ~b : b;
            c_d     = (sub == MODE_SUB) ? ~ci : ci;
            idx_d   = '0;
            state_d = RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            y_q     <= '0;
            c_q     <= 1'b0;
            co_q    <= 1'b0;
            ovf_q   <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            y_q     <= y_d;
            c_q     <= c_d;
            co_q    <= co_d;
            ovf_q   <= ovf_d;
            idx_q   <= idx_d;
        end
    end

endmodule

// File: tb/tb_sumador_multiciclo_param.sv
// Self-checking bench: directed cases plus random vectors on two configurations.
// Expected results come from a signed/unsigned integer arithmetic model.
module tb_sumador_multiciclo_param;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ci, sub;

    logic        iv16, or16, ir16, ov16, co16, vf16;
    logic [15:0] a16, b16, y16;

    logic        iv8, or8, ir8, ov8, co8, vf8;
    logic [7:0]  a8, b8, y8;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sumador_multiciclo_param #(.WIDTH(16), .CHUNK(4)) u_dut16 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (iv16),
        .in_ready  (ir16),
        .a         (a16),
        .b         (b16),
        .ci        (ci),
        .sub       (sub),
        .out_valid (ov16),
        .out_ready (or16),
        .y         (y16),
        .co        (co16),
        .ovf       (vf16)
    );

    sumador_multiciclo_param #(.WIDTH(8), .CHUNK(8)) u_dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (iv8),
        .in_ready  (ir8),
        .a         (a8),
        .b         (b8),
        .ci        (ci),
        .sub       (sub),
        .out_valid (ov8),
        .out_ready (or8),
        .y         (y8),
        .co        (co8),
        .ovf       (vf8)
    );

    task automatic check(input string tag, input longint got,
                         input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic rdy(input int w);
        return (w == 16) ? ir16 : ir8;
    endfunction

    function automatic logic vld(input int w);
        return (w == 16) ? ov16 : ov8;
    endfunction

    function automatic logic [15:0] yv(input int w);
        return (w == 16) ? y16 : {8'h00, y8};
    endfunction

    function automatic logic cov(input int w);
        return (w == 16) ? co16 : co8;
    endfunction

    function automatic logic vfv(input int w);
        return (w == 16) ? vf16 : vf8;
    endfunction

    // Reference: plain integer arithmetic on unsigned and signed views.
    task automatic model(input int w, input logic [15:0] av, bv,
                         input logic civ, subv,
                         output logic [15:0] ey,
                         output logic eco, eov);
        longint ua, ub, sa, sb, c, mask, half, r, sr;
        mask = (longint'(1) << w) - 1;
        half = longint'(1) << (w - 1);
        ua   = longint'(av) & mask;
        ub   = longint'(bv) & mask;
        c    = civ ? 1 : 0;
        sa   = (ua >= half) ? ua - (mask + 1) : ua;
        sb   = (ub >= half) ? ub - (mask + 1) : ub;
        if (!subv) begin
            r   = ua + ub + c;
            eco = (r > mask);
            sr  = sa + sb + c;
        end else begin
            r   = ua - ub - c;
            eco = (r >= 0);
            sr  = sa - sb - c;
        end
        ey  = 16'(r & mask);
        eov = (sr >= half) || (sr < -half);
    endtask

    // Accepts one operation (draining any pending result in the same edge),
    // then waits for the result and checks latency and values.
    // The result is left pending in DONE.
    task automatic op(input int w, input logic [15:0] av, bv,
                      input logic civ, subv);
        logic [15:0] ey;
        logic        eco, eov;
        int          n;
        model(w, av, bv, civ, subv, ey, eco, eov);
        ci  = civ;
        sub = subv;
        if (w == 16) begin
            a16 = av; b16 = bv; iv16 = 1'b1; or16 = 1'b1;
        end else begin
            a8 = av[7:0]; b8 = bv[7:0]; iv8 = 1'b1; or8 = 1'b1;
        end
        n = 0;
        while (!rdy(w) && n < 20) begin
            step();
            n++;
        end
        check("accept_ready", rdy(w), 1);
        step();
        iv16 = 1'b0; or16 = 1'b0; iv8 = 1'b0; or8 = 1'b0;
        a16 = 16'($urandom); b16 = 16'($urandom);
        a8  = 8'($urandom);  b8  = 8'($urandom);
        ci  = 1'($urandom);  sub = 1'($urandom);
        check("valid_drop_after_accept", vld(w), 0);
        n = 0;
        while (!vld(w) && n < 40) begin
            step();
            n++;
        end
        check("latency", n, (w == 16) ? 4 : 1);
        check("y", yv(w), ey);
        check("co", cov(w), eco);
        check("ovf", vfv(w), eov);
    endtask

    initial begin
        logic [15:0] hy;
        logic        hco, hvf;
        bit          seen;

        rst_n = 1'b0;
        iv16 = 1'b1; or16 = 1'b0; a16 = 16'h1234; b16 = 16'h1111;
        iv8  = 1'b1; or8  = 1'b0; a8  = 8'h12;    b8  = 8'h11;
        ci = 1'b0; sub = 1'b0;

        step();
        step();
        check("rst_in_ready16", ir16, 0);
        check("rst_out_valid16", ov16, 0);
        check("rst_y16", y16, 0);
        check("rst_co16", co16, 0);
        check("rst_ovf16", vf16, 0);
        check("rst_in_ready8", ir8, 0);
        check("rst_out_valid8", ov8, 0);

        iv16 = 1'b0; iv8 = 1'b0;
        rst_n = 1'b1;
        #1;
        check("rel_in_ready16", ir16, 1);
        step();
        step();
        check("no_spurious16", ov16, 0);
        check("idle_ready16", ir16, 1);
        check("no_spurious8", ov8, 0);

        op(16, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
        op(16, 16'h7FFF, 16'h0001, 1'b0, 1'b0);
        op(16, 16'h0005, 16'h0007, 1'b0, 1'b1);
        op(16, 16'h8000, 16'h0001, 1'b0, 1'b1);
        op(16, 16'h0010, 16'h0001, 1'b1, 1'b1);

        // Hold the last result under backpressure.
        hy = y16; hco = co16; hvf = vf16;
        for (int i = 0; i < 5; i++) begin
            iv16 = 1'b1;
            step();
            check("bp_valid", ov16, 1);
            check("bp_y", y16, hy);
            check("bp_co", co16, hco);
            check("bp_ovf", vf16, hvf);
            check("bp_in_ready", ir16, 0);
        end
        iv16 = 1'b0;
        op(16, 16'h0001, 16'h0002, 1'b0, 1'b0);

        // Reset during RUN aborts the operation.
        or16 = 1'b1;
        step();
        or16 = 1'b0;
        a16 = 16'h00AA; b16 = 16'h0055; ci = 1'b0; sub = 1'b0;
        iv16 = 1'b1;
        step();
        iv16 = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        step();
        check("abort_valid", ov16, 0);
        check("abort_y", y16, 0);
        check("abort_ready_low", ir16, 0);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (ov16) seen = 1'b1;
        end
        check("abort_no_valid", seen, 0);
        check("abort_ready", ir16, 1);
        op(16, 16'h0003, 16'h0004, 1'b0, 1'b0);

        op(8, 16'h00C8, 16'h0064, 1'b0, 1'b0);
        op(8, 16'h0080, 16'h0001, 1'b0, 1'b1);

        for (int i = 0; i < 200; i++) begin
            op(16, 16'($urandom), 16'($urandom),
               1'($urandom), 1'($urandom));
            for (int k = $urandom_range(0, 2); k > 0; k--) step();
        end
        for (int i = 0; i < 200; i++) begin
            op(8, 16'($urandom), 16'($urandom),
               1'($urandom), 1'($urandom));
            for (int k = $urandom_range(0, 2); k > 0; k--) step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
